// File: rtl/wm8978_i2c_wr.sv
// wm8978_i2c_wr: write-only I2C master issuing one 3-byte register write to the WM8978 per exec strobe
module wm8978_i2c_wr #(
    parameter logic [6:0] SLAVE_ADDR = 7'h1A,
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_exec,
    input  logic [15:0] i2c_data,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        busy,
    output logic        scl,
    inout  tri          sda
);
    localparam int CLK_DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW      = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("wm8978_i2c_wr: CLK_DIV must be >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, BYTE0, BYTE1, BYTE2, STOP, FIN, DONE} state_t;

    state_t          state, state_n;
    logic [QW-1:0]   qcnt;
    logic [1:0]      phase;
    logic [2:0]      bitcnt;
    logic            ack_slot;
    logic [15:0]     shift_data;
    logic            sda_q;
    logic            scl_n, sda_n;
    logic            run, qtick, slot_end, in_byte;
    logic [7:0]      cur_byte;

    assign run      = state inside {START, BYTE0, BYTE1, BYTE2, STOP};
    assign qtick    = run && qcnt == QW'(CLK_DIV - 1);
    assign slot_end = qtick && phase == 2'd3;
    assign in_byte  = state inside {BYTE0, BYTE1, BYTE2};
    assign cur_byte = state == BYTE0 ? {SLAVE_ADDR, 1'b0} :
                      state == BYTE1 ? shift_data[15:8] : shift_data[7:0];
    assign busy     = state != IDLE;
    assign i2c_done = state == DONE;
    assign sda      = sda_q ? 1'bz : 1'b0;

    // next-state sequencing and per-phase bus levels
    always_comb begin
        state_n = state;
        scl_n   = 1'b1;
        sda_n   = 1'b1;
        case (state)
            IDLE:  if (i2c_exec) state_n = START;
            START: begin
                if (slot_end) state_n = BYTE0;
                scl_n = phase != 2'd3;
                sda_n = !phase[1];
            end
            BYTE0, BYTE1, BYTE2: begin
                if (slot_end && ack_slot)
                    state_n = (i2c_ack || state == BYTE2) ? STOP : state_t'(state + 3'd1);
                scl_n = phase[0] ^ phase[1];
                sda_n = ack_slot | cur_byte[bitcnt];
            end
            STOP: begin
                if (slot_end) state_n = FIN;
                scl_n = phase != 2'd0;
                sda_n = phase[1];
            end
            FIN:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // quarter/phase timing, bit counting, data latch, ACK sampling and registered pin levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt       <= '0;
            phase      <= 2'd0;
            bitcnt     <= 3'd0;
            ack_slot   <= 1'b0;
            shift_data <= 16'd0;
            i2c_ack    <= 1'b0;
            scl        <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl   <= scl_n;
            sda_q <= sda_n;
            qcnt  <= run ? (qtick ? '0 : qcnt + 1'b1) : '0;
            phase <= run ? (qtick ? phase + 2'd1 : phase) : 2'd0;
            if (state == IDLE && i2c_exec) begin
                shift_data <= i2c_data;
                i2c_ack    <= 1'b0;
            end
            if (in_byte && ack_slot && qtick && phase == 2'd2 && sda != 1'b0)
                i2c_ack <= 1'b1;
            if (slot_end && (state == START || (in_byte && ack_slot))) begin
                bitcnt   <= 3'd7;
                ack_slot <= 1'b0;
            end else if (slot_end && in_byte) begin
                if (bitcnt == 3'd0) ack_slot <= 1'b1;
                else                bitcnt   <= bitcnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_wm8978_i2c_wr.sv
// tb_wm8978_i2c_wr: randomized scoreboard bench with an I2C slave model for wm8978_i2c_wr
module tb_wm8978_i2c_wr;
    localparam int CLK_DIV = 4_000_000 / (4 * 250_000);
    localparam int SLOT    = 4 * CLK_DIV;

    logic        clk = 0;
    logic        rst_n;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done, i2c_ack, busy, scl;
    wire         sda;
    logic        drv;

    pullup(sda);
    assign sda = drv ? 1'b0 : 1'bz;

    wm8978_i2c_wr #(.SLAVE_ADDR(7'h1A), .CLK_FREQ(4_000_000), .I2C_FREQ(250_000)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_exec(i2c_exec), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_ack(i2c_ack), .busy(busy), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // slave model: decodes START/bytes/STOP, ACKs every byte except index nack_idx
    int         nack_idx = 3;
    logic       ignore = 0;
    logic       in_tx = 0;
    int         bits = 0;
    int         rises = 0;
    int         viol = 0;
    logic [7:0] sh = 0;
    logic [7:0] rx[$];

    always @(negedge sda) if (!ignore && scl === 1'b1) begin
        if (in_tx) viol++;
        in_tx = 1;
        bits  = 0;
        rises = 0;
        rx.delete();
    end

    always @(posedge sda) if (!ignore && scl === 1'b1 && in_tx) begin
        if (bits != 1) viol++;
        in_tx = 0;
    end

    always @(posedge scl) if (!ignore && in_tx) begin
        rises++;
        if (bits < 8) begin
            sh = {sh[6:0], sda};
            if (bits == 7) rx.push_back(sh);
        end
        bits++;
    end

    always @(negedge scl) if (!ignore && in_tx) begin
        if (bits == 8) drv = (rx.size() - 1) != nack_idx;
        else if (bits == 9) begin
            drv  = 0;
            bits = 0;
        end
    end

    typedef struct {
        int          exec_cyc;
        int          n;
        bit          nack;
        logic [23:0] bytes;
    } exp_t;
    exp_t sb[$];

    exp_t        me;
    logic [23:0] got;

    // monitor: every done pulse is matched against the oldest expected transaction
    always @(negedge clk) if (rst_n && i2c_done) begin
        chk("done_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            me  = sb.pop_front();
            got = 0;
            foreach (rx[i]) got = {got[15:0], rx[i]};
            chk("latency", cyc - me.exec_cyc, (2 + 9 * me.n) * SLOT + 1);
            chk("ack_flag", i2c_ack, me.nack);
            chk("busy_at_done", busy, 1);
            chk("byte_count", rx.size(), me.n);
            chk("bytes", got, me.bytes);
            chk("scl_rises", rises, 9 * me.n + 1);
            chk("protocol", viol, 0);
            chk("stop_seen", in_tx, 0);
        end
    end

    task automatic issue(input logic [15:0] d, input int k);
        exp_t e;
        @(negedge clk);
        nack_idx   = k;
        i2c_data   = d;
        i2c_exec   = 1;
        e.n        = k < 3 ? k + 1 : 3;
        e.exec_cyc = cyc + 1;
        e.nack     = k < 3;
        e.bytes    = 24'({8'h34, d} >> (8 * (3 - e.n)));
        sb.push_back(e);
        @(negedge clk);
        i2c_exec = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        chk("drained", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !i2c_done; i++) @(negedge clk);
        chk("done_seen", i2c_done, 1);
    endtask

    int k;
    int t0;

    initial begin
        rst_n    = 0;
        i2c_exec = 0;
        i2c_data = 0;
        drv      = 0;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", i2c_done, 0);
        chk("rst_ack", i2c_ack, 0);
        rst_n = 1;

        issue(16'h0201, 3);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 5);
            issue(16'($urandom), k > 3 ? 3 : k);
            wait_idle();
        end

        issue(16'($urandom), 0);
        wait_idle();

        issue(16'h0201, 3);
        repeat (98) @(negedge clk);
        i2c_data = 16'hFFFF;
        i2c_exec = 1;
        @(negedge clk);
        i2c_exec = 0;
        wait_done();
        i2c_data = 16'hFFFF;
        i2c_exec = 1;
        @(negedge clk);
        i2c_exec = 0;
        repeat (600) @(negedge clk);
        chk("ignored_exec_idle", busy, 0);
        chk("ignored_exec_drained", sb.size(), 0);

        issue(16'($urandom), 1);
        wait_done();
        issue(16'h0C0F, 3);
        wait_idle();

        issue(16'($urandom), 3);
        t0 = sb[0].exec_cyc;
        while (cyc < t0 + 14 * SLOT + 6) @(negedge clk);
        ignore = 1;
        rst_n  = 0;
        #1;
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", i2c_done, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        in_tx = 0;
        bits  = 0;
        drv   = 0;
        rx.delete();
        ignore = 0;
        repeat (5) @(negedge clk);
        chk("postrst_busy", busy, 0);

        issue(16'($urandom), 3);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
